pc_gen: RTL and testbench

Parametrised program-counter generator for the pipelined RV32 core, and the next generation of the fetch-stage PC register. It holds the fetch address and applies a one-cycle boot bubble after reset, with a fixed priority among trap, EX-stage redirect, hazard stall and sequential increment. A small direct-mapped branch target buffer (BTB) can be compiled in to predict taken control flow. It sits in IF and drives the instruction memory address plus the IF/ID PC pipeline register.

---
 rtl/pc_gen.sv | 141 ++++++++++++++
 tb/tb_pc_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Brief    : IF-stage program-counter generator with a one-cycle boot bubble,
//            trap > redirect > stall > BTB > sequential priority, and an
//            optional direct-mapped BTB compiled in with `define PC_BTB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_VEC = '0,
    parameter int                STEP      = 4,
    parameter int                BTB_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [XLEN-1:0]      redirect_pc_i,
    input  logic                 trap_i,
    input  logic [XLEN-1:0]      trap_vec_i,
    input  logic                 btb_upd_i,
    input  logic [XLEN-1:0]      btb_upd_pc_i,
    input  logic [XLEN-1:0]      btb_upd_tgt_i,
    output logic [XLEN-1:0]      pc_o,
    output logic                 pc_valid_o,
    output logic                 pred_taken_o
);

    localparam logic [XLEN-1:0] c_align_mask = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] c_step       = XLEN'(STEP);

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_nxt;
    logic              r_pc_valid;
    logic              w_pred;
    logic              w_btb_hit;
    logic [XLEN-1:0]   w_btb_tgt;

`ifdef PC_BTB_EN
    localparam int c_idx_w = $clog2(BTB_DEPTH);
    localparam int c_tag_w = XLEN - c_idx_w - 2;

    logic [BTB_DEPTH-1:0]  r_btb_vld;
    logic [c_tag_w-1:0]    r_btb_tag [BTB_DEPTH];
    logic [XLEN-1:0]       r_btb_tgt [BTB_DEPTH];

    logic [c_idx_w-1:0]    w_lk_idx;
    logic [c_tag_w-1:0]    w_lk_tag;
    logic [c_idx_w-1:0]    w_up_idx;
    logic [c_tag_w-1:0]    w_up_tag;
    logic                  w_unused_upd_lsb;

    assign w_lk_idx         = r_pc[c_idx_w+1:2];
    assign w_lk_tag         = r_pc[XLEN-1:c_idx_w+2];
    assign w_up_idx         = btb_upd_pc_i[c_idx_w+1:2];
    assign w_up_tag         = btb_upd_pc_i[XLEN-1:c_idx_w+2];
    assign w_unused_upd_lsb = ^btb_upd_pc_i[1:0];

    // Only the valid bits need reset; tag/target are qualified by them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_btb_vld <= '0;
        end else if (btb_upd_i) begin
            r_btb_vld[w_up_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && btb_upd_i) begin
            r_btb_tag[w_up_idx] <= w_up_tag;
            r_btb_tgt[w_up_idx] <= btb_upd_tgt_i & c_align_mask;
        end
    end

    // Lookup reads pre-edge contents, so a same-cycle update is seen next cycle.
    assign w_btb_hit = r_btb_vld[w_lk_idx] && (r_btb_tag[w_lk_idx] == w_lk_tag);
    assign w_btb_tgt = r_btb_tgt[w_lk_idx];
`else
    logic w_unused_btb;

    assign w_unused_btb = ^{btb_upd_i, btb_upd_pc_i, btb_upd_tgt_i};
    assign w_btb_hit    = 1'b0;
    assign w_btb_tgt    = '0;
`endif

    always_comb begin
        w_state_nxt = ST_RUN;
        w_pc_nxt    = r_pc;
        w_pred      = 1'b0;
        case (r_state)
            ST_BOOT: begin
                // Stall is ignored here: the bubble always lasts one cycle.
                if (trap_i) begin
                    w_pc_nxt = trap_vec_i & c_align_mask;
                end else if (redirect_i) begin
                    w_pc_nxt = redirect_pc_i & c_align_mask;
                end
            end
            default: begin
                if (trap_i) begin
                    w_pc_nxt = trap_vec_i & c_align_mask;
                end else if (redirect_i) begin
                    w_pc_nxt = redirect_pc_i & c_align_mask;
                end else if (stall_i) begin
                    w_pc_nxt = r_pc;
                end else if (w_btb_hit) begin
                    w_pc_nxt = w_btb_tgt;
                    w_pred   = 1'b1;
                end else begin
                    w_pc_nxt = r_pc + c_step;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VEC;
            r_pc_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pc_valid <= (w_state_nxt == ST_RUN);
        end
    end

    assign pc_o         = r_pc;
    assign pc_valid_o   = r_pc_valid;
    assign pred_taken_o = w_pred;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Brief    : Self-checking bench for pc_gen: directed scenarios followed by
//            random traffic against a rule-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    localparam int          BD       = 8;
    localparam int          IW       = 3;
    localparam logic [31:0] WRAP_VEC = 32'hFFFF_FFF8;
`ifdef PC_BTB_EN
    localparam bit          BTB_ON   = 1'b1;
`else
    localparam bit          BTB_ON   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, redirect_i, trap_i, btb_upd_i;
    logic [31:0] redirect_pc_i, trap_vec_i, btb_upd_pc_i, btb_upd_tgt_i;
    logic [31:0] pc_o;
    logic        pc_valid_o, pred_taken_o;

    logic        z1  = 1'b0;
    logic [31:0] z32 = 32'h0;
    logic [31:0] w_pc;
    logic        w_valid, w_pred;

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .STEP(4), .BTB_DEPTH(BD)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .trap_i(trap_i), .trap_vec_i(trap_vec_i),
        .btb_upd_i(btb_upd_i), .btb_upd_pc_i(btb_upd_pc_i), .btb_upd_tgt_i(btb_upd_tgt_i),
        .pc_o(pc_o), .pc_valid_o(pc_valid_o), .pred_taken_o(pred_taken_o)
    );

    pc_gen #(.XLEN(32), .RESET_VEC(WRAP_VEC), .STEP(4), .BTB_DEPTH(BD)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall_i(z1), .redirect_i(z1),
        .redirect_pc_i(z32), .trap_i(z1), .trap_vec_i(z32),
        .btb_upd_i(z1), .btb_upd_pc_i(z32), .btb_upd_tgt_i(z32),
        .pc_o(w_pc), .pc_valid_o(w_valid), .pred_taken_o(w_pred)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: fetch address, boot flag and a table of recorded branches.
    bit          m_boot;
    logic [31:0] m_pc;
    bit          m_bv   [BD];
    logic [31:0] m_bpc  [BD];
    logic [31:0] m_btgt [BD];

    function automatic bit m_lookup(input logic [31:0] pc, output logic [31:0] tgt);
        int idx;
        idx = int'((pc >> 2) % BD);
        tgt = m_btgt[idx];
        return BTB_ON && m_bv[idx] && ((m_bpc[idx] >> (IW + 2)) == (pc >> (IW + 2)));
    endfunction

    function automatic bit m_pred();
        logic [31:0] t;
        return !m_boot && !stall_i && !redirect_i && !trap_i && m_lookup(m_pc, t);
    endfunction

    function automatic void m_edge();
        logic [31:0] t;
        bit          hit;
        int          idx;
        if (!rst_n) begin
            m_boot = 1'b1;
            m_pc   = 32'h0;
            foreach (m_bv[k]) m_bv[k] = 1'b0;
            return;
        end
        hit = m_lookup(m_pc, t);
        if (trap_i)              m_pc = trap_vec_i & ~32'h3;
        else if (redirect_i)     m_pc = redirect_pc_i & ~32'h3;
        else if (m_boot)         m_pc = m_pc;
        else if (stall_i)        m_pc = m_pc;
        else if (hit)            m_pc = t;
        else                     m_pc = m_pc + 32'd4;
        m_boot = 1'b0;
        if (BTB_ON && btb_upd_i) begin
            idx         = int'((btb_upd_pc_i >> 2) % BD);
            m_bv[idx]   = 1'b1;
            m_bpc[idx]  = btb_upd_pc_i;
            m_btgt[idx] = btb_upd_tgt_i & ~32'h3;
        end
    endfunction

    task automatic drive(input bit s, input bit r, input logic [31:0] rp, input bit t,
                         input logic [31:0] tv, input bit u, input logic [31:0] up,
                         input logic [31:0] ut);
        stall_i = s; redirect_i = r; redirect_pc_i = rp; trap_i = t; trap_vec_i = tv;
        btb_upd_i = u; btb_upd_pc_i = up; btb_upd_tgt_i = ut;
        #1;
        check("pred", {31'b0, pred_taken_o}, {31'b0, m_pred()});
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
        check("pc", pc_o, m_pc);
        check("valid", {31'b0, pc_valid_o}, {31'b0, !m_boot});
    endtask

    initial begin
        logic [31:0] upc;
        rst_n = 1'b0;
        stall_i = 0; redirect_i = 0; trap_i = 0; btb_upd_i = 0;
        redirect_pc_i = 0; trap_vec_i = 0; btb_upd_pc_i = 0; btb_upd_tgt_i = 0;
        @(posedge clk);
        m_edge();
        #1;
        check("rst_pc", pc_o, 32'h0);
        check("rst_valid", {31'b0, pc_valid_o}, 32'h0);
        check("rst_pred", {31'b0, pred_taken_o}, 32'h0);
        check("wrap_rst", w_pc, WRAP_VEC);
        rst_n = 1'b1;

        // Boot bubble then sequential fetch; the wrap instance rolls over to 0.
        idle(); step(); check("seq0", pc_o, 32'h0);  check("boot_done", {31'b0, pc_valid_o}, 32'h1);
        check("wrap0", w_pc, 32'hFFFF_FFF8);
        idle(); step(); check("seq4", pc_o, 32'h4);  check("wrap1", w_pc, 32'hFFFF_FFFC);
        idle(); step(); check("seq8", pc_o, 32'h8);  check("wrap2", w_pc, 32'h0);
        idle(); step(); check("seq12", pc_o, 32'hC);
        idle(); step(); check("seq16", pc_o, 32'h10);

        // Redirect beats stall and is word-aligned.
        drive(1'b1, 1'b1, 32'h103, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(); check("redir_stall", pc_o, 32'h100);
        idle(); step(); check("redir_next", pc_o, 32'h104);

        // Trap beats redirect.
        drive(1'b0, 1'b1, 32'h200, 1'b1, 32'h80, 1'b0, 32'h0, 32'h0);
        step(); check("trap_wins", pc_o, 32'h80);

        drive(1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(); check("to_20", pc_o, 32'h20);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
            step(); check("stall_hold", pc_o, 32'h20);
        end
        idle(); step(); check("stall_release", pc_o, 32'h24);

`ifdef PC_BTB_EN
        drive(1'b0, 1'b1, 32'h3C, 1'b0, 32'h0, 1'b1, 32'h40, 32'h400);
        step(); check("btb_pre", pc_o, 32'h3C);
        idle(); step(); check("btb_at40", pc_o, 32'h40);
        idle(); check("btb_hit_pred", {31'b0, pred_taken_o}, 32'h1);
        step(); check("btb_taken", pc_o, 32'h400);
        drive(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h60, 32'h600);
        step(); check("btb_revisit", pc_o, 32'h40);
        idle(); check("btb_alias_pred", {31'b0, pred_taken_o}, 32'h0);
        step(); check("btb_alias_next", pc_o, 32'h44);
`endif

        // Random traffic, with occasional mid-run resets carrying live inputs.
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            upc = ($urandom_range(0, 1) == 1) ? m_pc + 32'($urandom_range(0, 6)) * 4
                                              : 32'($urandom_range(0, 1023));
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  32'($urandom_range(0, 1023)), $urandom_range(0, 15) == 0,
                  32'($urandom_range(0, 1023)), $urandom_range(0, 3) == 0,
                  upc, 32'($urandom_range(0, 1023)));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
